// File: rtl/rv32i_encoder.sv
// rv32i_encoder: two-stage RV32I instruction packer.
//   Takes decoded fields (opcode, funct3, funct7, rd/rs1/rs2, immediate),
//   picks the ISA format from the opcode, checks the immediate, and emits
//   the 32-bit instruction word. Errors produce a zero word plus a code.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input stream handshake
//   in_opcode..in_imm     decoded instruction fields
//   out_valid/out_ready   output stream handshake
//   out_inst              packed instruction (0 on error)
//   out_error(_code)      0 none, 1 illegal opcode, 2 imm range, 3 misaligned
//   encoded_count         error-free output handshakes, wraps
module rv32i_encoder #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     out_error,
  output logic [1:0]               out_error_code,
  output logic [COUNTER_WIDTH-1:0] encoded_count
);

  typedef enum logic [2:0] {
    FMT_R, FMT_SH, FMT_I, FMT_S, FMT_U, FMT_B, FMT_J, FMT_BAD
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  err;
  } s1_t;

  // vld_pipe[1] = check stage full, vld_pipe[2] = pack/output stage full
  logic [2:1] vld_pipe;
  s1_t        s1_q, s1_d;
  logic       s1_adv, s2_adv;
  logic       rng_ok, mis;
  logic [31:0] pk;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = vld_pipe[2];

  // Format select and immediate checks on the incoming fields.
  always_comb begin
    s1_d.fmt    = FMT_BAD;
    s1_d.opcode = in_opcode;
    s1_d.funct3 = in_funct3;
    s1_d.funct7 = in_funct7;
    s1_d.rd     = in_rd;
    s1_d.rs1    = in_rs1;
    s1_d.rs2    = in_rs2;
    s1_d.imm    = in_imm;
    rng_ok      = 1'b1;
    mis         = 1'b0;
    case (in_opcode)
      7'h33: s1_d.fmt = FMT_R;
      7'h13: s1_d.fmt = (in_funct3 == 3'd1 || in_funct3 == 3'd5) ? FMT_SH : FMT_I;
      7'h03, 7'h67, 7'h73, 7'h0F: s1_d.fmt = FMT_I;
      7'h23: s1_d.fmt = FMT_S;
      7'h37, 7'h17: s1_d.fmt = FMT_U;
      7'h63: s1_d.fmt = FMT_B;
      7'h6F: s1_d.fmt = FMT_J;
      default: s1_d.fmt = FMT_BAD;
    endcase
    // Signed-range checks: all bits above the sign bit must match it.
    case (s1_d.fmt)
      FMT_SH:       rng_ok = ~|in_imm[31:5];
      FMT_I, FMT_S: rng_ok = (in_imm[31:11] == {21{in_imm[11]}});
      FMT_U:        rng_ok = ~|in_imm[11:0];
      FMT_B: begin
        rng_ok = (in_imm[31:12] == {20{in_imm[12]}});
        mis    = in_imm[0];
      end
      FMT_J: begin
        rng_ok = (in_imm[31:20] == {12{in_imm[20]}});
        mis    = in_imm[0];
      end
      default: rng_ok = 1'b1;
    endcase
    // Priority: illegal opcode > misaligned > range.
    if (s1_d.fmt == FMT_BAD) s1_d.err = 2'd1;
    else if (mis)            s1_d.err = 2'd3;
    else if (!rng_ok)        s1_d.err = 2'd2;
    else                     s1_d.err = 2'd0;
  end

  // Bit packing from the registered fields.
  always_comb begin
    pk = 32'h0;
    case (s1_q.fmt)
      FMT_R:  pk = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_SH: pk = {s1_q.funct7, s1_q.imm[4:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_I:  pk = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_S:  pk = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.imm[4:0],
                    s1_q.opcode};
      FMT_U:  pk = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_B:  pk = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                    s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_J:  pk = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                    s1_q.rd, s1_q.opcode};
      default: pk = 32'h0;
    endcase
    if (s1_q.err != 2'd0) pk = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe       <= '0;
      s1_q           <= '0;
      out_inst       <= '0;
      out_error      <= 1'b0;
      out_error_code <= 2'd0;
      encoded_count  <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_inst       <= pk;
          out_error      <= |s1_q.err;
          out_error_code <= s1_q.err;
        end
      end
      if (vld_pipe[2] && out_ready && !out_error)
        encoded_count <= encoded_count + 1'b1;
    end
  end

endmodule
